// File: rtl/ln_pkg.sv
// Shared constants, state type and coefficient table for the ln(y) datapath.
// LN_ROUND_EN adds one guard iteration (k = -1) so the result can be rounded.
package ln_pkg;

    localparam int DATA_SIZE = 16;
    localparam int PROD_W    = 33;
    localparam int LUT_W     = 16;
    localparam int LUT_DEPTH = 13;
    localparam int CNT_W     = 4;

`ifdef LN_ROUND_EN
    localparam int LN_ITERS = 13;
`else
    localparam int LN_ITERS = 12;
`endif

    localparam logic [CNT_W-1:0]  CNT_START = 4'd12;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(13 - LN_ITERS);
    localparam logic [PROD_W-1:0] P_INIT    = 33'h1_0000_0000;
    localparam logic [15:0]       SAT_NEG   = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_HOLD
    } ln_state_e;

    // Entry j holds e^-(2^(j-9)) in 0.16; j = k + 1, so entry 0 is the guard step.
    localparam logic [LUT_W-1:0] LN_LUT [LUT_DEPTH] = '{
        16'd65408, 16'd65280, 16'd65026, 16'd64520, 16'd63520,
        16'd61565, 16'd57835, 16'd51039, 16'd39750, 16'd24109,
        16'd8869,  16'd1200,  16'd22
    };

    function automatic logic [15:0] ln_negate(input logic [11:0] mag);
        return ~{4'b0, mag} + 16'd1;
    endfunction

endpackage

// File: rtl/ln_lut_16.sv
// Combinational coefficient ROM indexed by the iteration counter.
// Indices past the table return 0, which never passes the greedy compare.
module ln_lut_16
    import ln_pkg::*;
(
    input  logic [CNT_W-1:0] idx_i,
    output logic [LUT_W-1:0] coef_o
);

    localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(LUT_DEPTH - 1);

    always_comb begin
        coef_o = '0;
        if (idx_i <= IDX_MAX) begin
            coef_o = LN_LUT[idx_i];
        end
    end

endmodule

// File: rtl/ln_1_block_16.sv
// ln(y) for a 0.16 operand by greedy exp-product bit decomposition, 1.7.8 result.
// Define LN_ROUND_EN for a guard iteration and rounded (saturating) output.
module ln_1_block_16
    import ln_pkg::*;
#(
    parameter int data_size = DATA_SIZE
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [data_size-1:0] ln_data_i,
    input  logic                 ln_data_valid_i,
    input  logic                 ln_last_i,
    output logic                 ln_ready_o,
    output logic [data_size-1:0] ln_data_o,
    output logic                 ln_data_valid_o,
    input  logic                 ln_data_ready_i,
    output logic                 ln_done_o
);

    ln_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PROD_W-1:0]        p_q, p_d;
    logic [LN_ITERS-1:0]      x_q, x_d;
    logic [data_size-1:0]     y_q, y_d;
    logic                     last_q, last_d;
    logic                     ready_q, ready_d;
    logic [data_size-1:0]     data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;

    logic [LUT_W-1:0]         coef;
    logic [PROD_W-1:0]        t;
    logic                     take;
    logic [CNT_W-1:0]         bit_idx;
    logic [11:0]              x_res;
`ifdef LN_ROUND_EN
    logic [12:0]              x_sum;
`endif

    ln_lut_16 u_lut (
        .idx_i  (cnt_q),
        .coef_o (coef)
    );

    // Keep bits [48:16] of the 1.32 x 0.16 product so t stays in 1.32.
    assign t       = PROD_W'(({16'b0, p_q} * {33'b0, coef}) >> 16);
    assign take    = (t >= {1'b0, y_q, 16'b0});
    assign bit_idx = cnt_q - CNT_LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        x_d     = x_q;
        y_d     = y_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
        x_res   = '0;
`ifdef LN_ROUND_EN
        x_sum   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ln_data_valid_i && ready_q) begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_START;
                    p_d     = P_INIT;
                    x_d     = '0;
                    y_d     = ln_data_i;
                    last_d  = ln_last_i;
                end
            end
            ST_CALC: begin
                if (y_q == '0) begin
                    state_d = ST_HOLD;
                    data_d  = SAT_NEG;
                    valid_d = 1'b1;
                end else begin
                    if (take) begin
                        p_d = t;
                    end
                    x_d[bit_idx] = take;
                    cnt_d        = cnt_q - 4'd1;
                    if (cnt_q == CNT_LAST) begin
`ifdef LN_ROUND_EN
                        x_sum = {1'b0, x_d[12:1]} + {12'b0, x_d[0]};
                        x_res = x_sum[12] ? 12'hFFF : x_sum[11:0];
`else
                        x_res = x_d[11:0];
`endif
                        state_d = ST_HOLD;
                        data_d  = ln_negate(x_res);
                        valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (ln_data_ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    if (last_q) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign ln_ready_o      = ready_q;
    assign ln_data_o       = data_q;
    assign ln_data_valid_o = valid_q;
    assign ln_done_o       = done_q;

endmodule
